fp_div: RTL and testbench
=========================

# fp_div

Iterative IEEE-754 floating-point divider, the inverse-operation companion to the pipelined FP multiplier in the FPU. It accepts one operand pair through a ready/start handshake and computes `a/b` with a radix-2 restoring mantissa divider, one quotient bit per cycle. It produces a sign/exponent/fraction result using the same numeric conventions as the multiplier:

- no NaN generation
- zero and infinity override
- round-half-up on the guard bit

It sits beside the multiplier in the FP execute cluster and is shared by single- and double-precision issue via the `W` parameter.

## Interface
- `W`, 32: operand width; 32 gives FW=23 and EW=8, 64 gives FW=52 and EW=11.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; accepted only when `ready`=1.
- `a`  in  W  dividend; sampled on accept.
- `b`  in  W  divisor; sampled on accept.
- `ready`  out  1  high in IDLE (combinational from state).
- `y`  out  W  quotient; holds its value until the next completion.
- `y_valid`  out  1  one-cycle pulse when `y` is updated.

## Operation
- **Reset:** `y`=0, `y_valid`=0, state IDLE, so `ready`=1.
- **Accept:** on `start`&`ready`, latch `a`/`b` and go to CHECK. `start` while not ready is ignored; no queueing.
- **Zero test:** an operand is zero when exponent and fraction are both 0; the sign bit is ignored.
- **Sign:** always `a[W-1]^b[W-1]`.
- **Specials, in priority order:**
  1. `a` zero → exponent 0, fraction 0.
  2. `b` zero, or `a` exponent all-ones → exponent all-ones, fraction 0 (infinity).
  3. `b` exponent all-ones → zero.
- **Datapath:**
  - Mantissas `ma`={1,fa} and `mb`={1,fb}, FW+1 bits each.
  - Remainder `r` (FW+2 bits) starts at `ma`.
  - Each DIV cycle: if `r`>=`mb`, set the quotient bit to 1 and `r`=`r`-`mb`, else set it to 0; then shift `r` left by 1.
  - The quotient is FW+3 bits, MSB first; q[FW+2] is the integer bit.
- **Normalize:**
  - If q[FW+2]=1: fraction = q[FW+1:2], guard = q[1].
  - Else: fraction = q[FW:1], guard = q[0], and the exponent is decremented by 1.
- **Round:** if guard=1, fraction+1. On carry-out, fraction becomes 0 and the exponent is incremented by 1. No sticky bit, no RNE.
- **Exponent:** computed as ea − eb + bias (bias = 2^(EW−1)−1) in signed EW+2 bits, after the normalize and round adjustments.
  - Result >= all-ones → infinity.
  - Result <= 0 → zero (flush; denormals are never produced).
  - Denormal inputs are treated as having a hidden 1.
- **FSM:**
  - IDLE → CHECK on accept.
  - CHECK → DONE if special (early-out), else DIV with counter = FW+3.
  - DIV → ROUND when the counter reaches 0.
  - ROUND → DONE.
  - DONE (registers `y`, pulses `y_valid`) → IDLE.
- **Reset mid-operation:** abandon the operation; no `y_valid`; `y` returns to 0.

## Timing
- The accept edge is cycle 0. The FSM is in CHECK during cycle 1.
- **Normal operand:** DIV during cycles 2..FW+4, ROUND at FW+5, DONE at FW+6.
  - `y_valid` is high during cycle FW+6: 29 for fp32, 58 for fp64.
- **Special operand, early-out:** `y_valid` is high during cycle 2.
- `ready` returns high in the cycle after DONE; back-to-back starts are therefore spaced by latency+1.

## Configuration
- `FP_DIV_FIXED_LAT_EN`
  - **Defined:** specials still traverse DIV and ROUND with the datapath result discarded, so every operation has latency FW+6. This is for the fixed-latency writeback scheduler.
  - **Undefined:** specials take the early-out path, with latency 2.

## Structure
- **Package `fp_div_pkg`:** holds
  - the state enum typedef (IDLE, CHECK, DIV, ROUND, DONE);
  - functions `fw_of(W)` and `ew_of(W)`;
  - a special-class enum (NONE, ZERO, INF).
- **Sub-module `fp_div_round`:** combinational normalize, round and exponent-saturation stage. Takes the quotient, the pre-adjust exponent and the sign; returns the packed W-bit result. It is used in ROUND.

## Test plan
- **fp32 basic:** 0x40C00000 / 0x40000000 → `y`=0x40400000, `y_valid` at cycle 29.
- **Rounding and sign:**
  - 0x3F800000 / 0x40400000 → 0x3EAAAAAB (guard round-up).
  - 0xC0C00000 / 0x40000000 → 0xC0400000.
- **Specials, macro undefined:**
  - 0x3F800000 / 0x00000000 → 0x7F800000 at cycle 2.
  - 0x00000000 / 0x00000000 → 0x00000000.
  - 0x3F800000 / 0x7F800000 → 0x00000000.
  - With the macro defined, the same results arrive at cycle 29.
- **Range:**
  - 0x7F000000 / 0x00800000 → 0x7F800000 (overflow).
  - 0x00800000 / 0x7F000000 → 0x00000000 (underflow).
- **fp64:** W=64, 0x4018000000000000 / 0x4000000000000000 → 0x4008000000000000 at cycle 58.
- **Handshake and reset:**
  - `start` pulsed during DIV is ignored and the first result is unaffected.
  - `reset_n`=0 at cycle 10 → no `y_valid`, `y`=0, `ready`=1 the following cycle.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types and width helpers for the iterative FP divider.
//   state_e : divider FSM states
//   cls_e   : special-operand class resolved before the mantissa loop
//   fw_of / ew_of : fraction / exponent widths for a given operand width
package fp_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        ROUND,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ZERO,
        CLS_INF
    } cls_e;

    function automatic int unsigned fw_of(input int unsigned w);
        return (w == 64) ? 52 : 23;
    endfunction

    function automatic int unsigned ew_of(input int unsigned w);
        return (w == 64) ? 11 : 8;
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// Request/result bundle of the FP divider.
//   start, a, b     : requester -> divider (a/b sampled when start & ready)
//   ready           : divider idle and able to accept
//   y, y_valid      : quotient, and a one-cycle pulse when y is updated
interface fp_div_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic [W-1:0] y;
    logic         y_valid;

    modport master (
        output start, a, b,
        input  ready, y, y_valid
    );

    modport slave (
        input  start, a, b,
        output ready, y, y_valid
    );
endinterface

// File: rtl/fp_div_round.sv
// Normalize, round-half-up on the guard bit, and saturate the exponent.
//   q       : FW+3 bit quotient, MSB is the integer bit
//   exp_pre : ea - eb + bias, EW+2 bits two's complement
//   sign    : result sign
//   res_c   : packed W-bit result (combinational)
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter  int unsigned W  = 32,
    localparam int unsigned FW = fw_of(W),
    localparam int unsigned EW = ew_of(W)
) (
    input  logic [FW+2:0] q,
    input  logic [EW+1:0] exp_pre,
    input  logic          sign,
    output logic [W-1:0]  res_c
);

    localparam logic [EW+1:0] EMAX = (EW+2)'((1 << EW) - 1);

    logic [FW-1:0] frac_n;
    logic          guard;
    logic [EW+1:0] exp_n;
    logic [EW+1:0] exp_r;
    logic [FW:0]   sum;
    logic          ovf;
    logic          unf;

    always_comb begin
        frac_n = q[FW:1];
        guard  = q[0];
        exp_n  = exp_pre - (EW+2)'(1);
        // Quotient in [1,2): keep exponent; in (0.5,1): shift by one, exponent already decremented
        if (q[FW+2]) begin
            frac_n = q[FW+1:2];
            guard  = q[1];
            exp_n  = exp_pre;
        end
        // Carry-out leaves sum[FW-1:0] at zero, which is the renormalized fraction
        sum   = {1'b0, frac_n} + (FW+1)'(guard);
        exp_r = sum[FW] ? exp_n + (EW+2)'(1) : exp_n;
        ovf   = !exp_r[EW+1] && (exp_r >= EMAX);
        unf   = exp_r[EW+1] || (exp_r == '0);
        res_c = {sign, exp_r[EW-1:0], sum[FW-1:0]};
        if (ovf) begin
            res_c = {sign, {EW{1'b1}}, FW'(0)};
        end else if (unf) begin
            res_c = {sign, (W-1)'(0)};
        end
    end

endmodule

// File: rtl/fp_div.sv
// Iterative IEEE-754 divider: radix-2 restoring mantissa loop, one quotient
// bit per cycle, zero/infinity overrides, round-half-up, no NaN, no denormals.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : start/a/b request, ready, y/y_valid result
// Build option FP_DIV_FIXED_LAT_EN: specials also run DIV/ROUND so every
// operation has the same latency; otherwise specials finish right after CHECK.
module fp_div
    import fp_div_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    fp_div_if.slave  bus
);

    localparam int unsigned FW = fw_of(W);
    localparam int unsigned EW = ew_of(W);
    localparam int unsigned QW = FW + 3;
    localparam int unsigned CW = $clog2(QW + 1);
    localparam logic [EW+1:0] BIAS = (EW+2)'((1 << (EW - 1)) - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, b_q;
    logic [FW+1:0] r_q;
    logic [QW-1:0] q_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  y_q;
    logic          y_valid_q;

    logic [EW-1:0] ea, eb;
    logic [FW-1:0] fa, fb;
    logic          sign_c;
    cls_e          cls_c;
    logic [W-1:0]  special_y_c;
    logic [W-1:0]  round_y_c;
    logic [EW+1:0] exp_pre_c;
    logic [FW+1:0] mb_c;
    logic          r_ge_c;
    logic [FW+1:0] r_sub_c;

    assign ea     = a_q[W-2:FW];
    assign eb     = b_q[W-2:FW];
    assign fa     = a_q[FW-1:0];
    assign fb     = b_q[FW-1:0];
    assign sign_c = a_q[W-1] ^ b_q[W-1];

    // Special classification in priority order; latched operands stay stable all operation
    always_comb begin
        cls_c = CLS_NONE;
        if (ea == '0 && fa == '0) begin
            cls_c = CLS_ZERO;
        end else if ((eb == '0 && fb == '0) || (&ea)) begin
            cls_c = CLS_INF;
        end else if (&eb) begin
            cls_c = CLS_ZERO;
        end
    end

    assign special_y_c = {sign_c, {EW{cls_c == CLS_INF}}, FW'(0)};
    assign exp_pre_c   = {2'b00, ea} - {2'b00, eb} + BIAS;

    // Restoring step; hidden 1 is forced even for denormal inputs
    assign mb_c    = {2'b01, fb};
    assign r_ge_c  = (r_q >= mb_c);
    assign r_sub_c = r_ge_c ? r_q - mb_c : r_q;

    fp_div_round #(.W(W)) u_round (
        .q       (q_q),
        .exp_pre (exp_pre_c),
        .sign    (sign_c),
        .res_c   (round_y_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = CHECK;
`ifdef FP_DIV_FIXED_LAT_EN
            CHECK: state_d = DIV;
`else
            CHECK: state_d = (cls_c == CLS_NONE) ? DIV : DONE;
`endif
            DIV:   if (cnt_q == CW'(1)) state_d = ROUND;
            ROUND: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, mantissa loop and registered result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                    end
                end
                CHECK: begin
                    r_q   <= {2'b01, fa};
                    q_q   <= '0;
                    cnt_q <= CW'(QW);
                    if (state_d == DONE) begin
                        y_q       <= special_y_c;
                        y_valid_q <= 1'b1;
                    end
                end
                DIV: begin
                    r_q   <= r_sub_c << 1;
                    q_q   <= {q_q[QW-2:0], r_ge_c};
                    cnt_q <= cnt_q - CW'(1);
                end
                ROUND: begin
                    // Specials only reach ROUND in the fixed-latency build
                    y_q       <= (cls_c == CLS_NONE) ? round_y_c : special_y_c;
                    y_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: fp32 vector table, handshake/reset
// sequences, an fp64 instance, and randomized fp32 against a reference model.
module tb_fp_div;

`ifdef FP_DIV_FIXED_LAT_EN
    localparam int SPEC_LAT32 = 29;
    localparam int SPEC_LAT64 = 58;
`else
    localparam int SPEC_LAT32 = 2;
    localparam int SPEC_LAT64 = 2;
`endif
    localparam int LAT32 = 29;
    localparam int LAT64 = 58;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fp_div_if #(.W(32)) if32();
    fp_div_if #(.W(64)) if64();

    fp_div #(.W(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
    fp_div #(.W(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(if64));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        bit          spec;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_vld(input bit w64);
        return w64 ? if64.y_valid : if32.y_valid;
    endfunction

    function automatic logic get_rdy(input bit w64);
        return w64 ? if64.ready : if32.ready;
    endfunction

    function automatic logic [63:0] get_y(input bit w64);
        return w64 ? if64.y : {32'b0, if32.y};
    endfunction

    task automatic set_in(input bit w64, input logic s, input logic [63:0] a, input logic [63:0] b);
        if (w64) begin
            if64.start = s; if64.a = a; if64.b = b;
        end else begin
            if32.start = s; if32.a = a[31:0]; if32.b = b[31:0];
        end
    endtask

    // Reference: real-number view of a/b, quotient by integer division of scaled mantissas
    function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        longint fa, fb, ma, mb, q, m, g;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        if (ea == 0 && fa == 0) return {s, 31'b0};
        if ((eb == 0 && fb == 0) || ea == 255) return {s, 8'hFF, 23'b0};
        if (eb == 255) return {s, 31'b0};
        ma = fa + (longint'(1) << 23);
        mb = fb + (longint'(1) << 23);
        q  = (ma << 25) / mb;
        e  = ea - eb + 127;
        if (q >= (longint'(1) << 25)) begin
            m = q >> 2;
            g = (q >> 1) & 1;
        end else begin
            m = q >> 1;
            g = q & 1;
            e = e - 1;
        end
        m = m + g;
        if (m == (longint'(1) << 24)) begin
            m = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) return {s, 31'b0};
        return {s, 8'(e), 23'(m)};
    endfunction

    function automatic bit is_special32(input logic [31:0] a, input logic [31:0] b);
        return (a[30:0] == 31'b0) || (b[30:0] == 31'b0) ||
               (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(90, 164));
        return v;
    endfunction

    // One operation: accept, wait for y_valid (bounded), check latency, value, pulse width and hold
    task automatic run_op(input bit w64, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_y, input int exp_lat,
                          input string name, input int glitch);
        int cyc;
        bit seen;
        @(negedge clk);
        cyc = 0;
        while (!get_rdy(w64) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s ready-before", name), 64'(get_rdy(w64)), 64'd1);
        set_in(w64, 1'b1, a, b);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) set_in(w64, 1'b0, a, b);
            if (glitch != 0 && cyc == glitch) set_in(w64, 1'b1, 64'h3F800000, 64'h0);
            if (glitch != 0 && cyc == glitch + 1) set_in(w64, 1'b0, a, b);
            seen = get_vld(w64);
        end
        check($sformatf("%s latency", name), 64'(cyc), 64'(exp_lat));
        check($sformatf("%s y", name), get_y(w64), exp_y);
        @(negedge clk);
        check($sformatf("%s valid-pulse", name), 64'(get_vld(w64)), 64'd0);
        check($sformatf("%s ready-after", name), 64'(get_rdy(w64)), 64'd1);
        @(negedge clk);
        check($sformatf("%s y-hold", name), get_y(w64), exp_y);
    endtask

    initial begin
        int vcount;
        logic [31:0] ra, rb;

        set_in(1'b0, 1'b0, 64'h0, 64'h0);
        set_in(1'b1, 1'b0, 64'h0, 64'h0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset y32", {32'b0, if32.y}, 64'h0);
        check("reset valid32", 64'(if32.y_valid), 64'd0);
        check("reset ready32", 64'(if32.ready), 64'd1);
        check("reset y64", if64.y, 64'h0);
        reset_n = 1'b1;

        tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        tbl[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
        tbl[2] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0};
        tbl[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1};
        tbl[4] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
        tbl[5] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b1};
        tbl[6] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0};
        tbl[7] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0};
        tbl[8] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1};
        tbl[9] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1};

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, {32'b0, tbl[i].a}, {32'b0, tbl[i].b}, {32'b0, tbl[i].y},
                   tbl[i].spec ? SPEC_LAT32 : LAT32, $sformatf("vec%0d", i), 0);
        end

        // start pulsed mid-DIV must be ignored
        run_op(1'b0, 64'h40C00000, 64'h40000000, 64'h40400000, LAT32, "glitch", 6);

        // Reset during DIV: abandon, clear y, ready next cycle, no late y_valid
        @(negedge clk);
        set_in(1'b0, 1'b1, 64'h3F800000, 64'h40400000);
        vcount = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) if32.start = 1'b0;
            if (if32.y_valid) vcount++;
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset y", {32'b0, if32.y}, 64'h0);
        check("midreset valid", 64'(if32.y_valid), 64'd0);
        check("midreset ready", 64'(if32.ready), 64'd1);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if32.y_valid) vcount++;
        end
        check("midreset no-valid", 64'(vcount), 64'd0);

        run_op(1'b1, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000,
               LAT64, "fp64 basic", 0);
        run_op(1'b1, 64'h3FF0000000000000, 64'h0, 64'h7FF0000000000000,
               SPEC_LAT64, "fp64 div0", 0);

        for (int i = 0; i < 60; i++) begin
            ra = rnd_fp();
            rb = rnd_fp();
            run_op(1'b0, {32'b0, ra}, {32'b0, rb}, {32'b0, ref32(ra, rb)},
                   is_special32(ra, rb) ? SPEC_LAT32 : LAT32,
                   $sformatf("rnd%0d %h/%h", i, ra, rb), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
